// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and optional first-word-fall-through.
module sync_fifo_param #(
  parameter int  DATA_W   = 8,
  parameter int  DEPTH    = 8,
  parameter int  AF_LEVEL = 6,
  parameter int  AE_LEVEL = 2,
  parameter bit  FWFT     = 1'b0,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] buf_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  fifo_cnt,
  output logic              overflow,
  output logic              underflow
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_out_q, buf_out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc, wr_acc;

  // Both accept decisions use pre-edge occupancy; a write into a full FIFO
  // only fits if a read frees a slot on the same edge.
  assign rd_acc = rd_en && (cnt_q != '0);
  assign wr_acc = wr_en && ((cnt_q != DEPTH_CNT) || rd_acc);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    buf_out_d   = buf_out_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (rst) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      buf_out_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        buf_out_d = mem_q[rd_ptr_q];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      overflow_d  = wr_en && !wr_acc;
      underflow_d = rd_en && !rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    cnt_q       <= cnt_d;
    buf_out_q   <= buf_out_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  // NOTE: storage has no reset; the pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr_q] <= buf_in;
  end

  // In FWFT mode buf_out_q remembers the last popped word for the empty case.
  assign buf_out      = (FWFT && !empty) ? mem_q[rd_ptr_q] : buf_out_q;
  assign fifo_cnt     = cnt_q;
  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == DEPTH_CNT);
  assign almost_full  = (cnt_q >= AF_CNT);
  assign almost_empty = (cnt_q <= AE_CNT);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-mode and an FWFT-mode FIFO from the same stimulus and
// checks both against a queue-based model every cycle.
module tb_sync_fifo_param;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] buf_in = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;

  logic [7:0] out_s, out_f;
  logic [3:0] cnt_s, cnt_f;
  logic       empty_s, full_s, af_s, ae_s, ovf_s, unf_s;
  logic       empty_f, full_f, af_f, ae_f, ovf_f, unf_f;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
    .buf_out(out_s), .empty(empty_s), .full(full_s), .almost_full(af_s),
    .almost_empty(ae_s), .fifo_cnt(cnt_s), .overflow(ovf_s), .underflow(unf_s)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
    .buf_out(out_f), .empty(empty_f), .full(full_f), .almost_full(af_f),
    .almost_empty(ae_f), .fifo_cnt(cnt_f), .overflow(ovf_f), .underflow(unf_f)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Behavioural model: a queue holds the stored words in order.
  logic [7:0] q[$];
  logic [7:0] exp_std  = '0;
  logic [7:0] exp_last = '0;
  logic       exp_ovf  = 1'b0;
  logic       exp_unf  = 1'b0;
  bit         model_valid = 1'b0;
  bit         m_rd, m_wr;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      exp_std     = '0;
      exp_last    = '0;
      exp_ovf     = 1'b0;
      exp_unf     = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_rd = rd_en && (q.size() > 0);
      m_wr = wr_en && ((q.size() < DEPTH) || m_rd);
      if (m_rd) begin
        exp_std  = q.pop_front();
        exp_last = exp_std;
      end
      if (m_wr) q.push_back(buf_in);
      exp_ovf = wr_en && !m_wr;
      exp_unf = rd_en && !m_rd;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      int n;
      logic [7:0] exp_fw;
      n = q.size();
      exp_fw = (n > 0) ? q[0] : exp_last;
      check("std_cnt",   32'(cnt_s),   32'(n));
      check("std_empty", 32'(empty_s), 32'(n == 0));
      check("std_full",  32'(full_s),  32'(n == DEPTH));
      check("std_af",    32'(af_s),    32'(n >= AF));
      check("std_ae",    32'(ae_s),    32'(n <= AE));
      check("std_ovf",   32'(ovf_s),   32'(exp_ovf));
      check("std_unf",   32'(unf_s),   32'(exp_unf));
      check("std_out",   32'(out_s),   32'(exp_std));
      check("fw_cnt",    32'(cnt_f),   32'(n));
      check("fw_empty",  32'(empty_f), 32'(n == 0));
      check("fw_full",   32'(full_f),  32'(n == DEPTH));
      check("fw_af",     32'(af_f),    32'(n >= AF));
      check("fw_ae",     32'(ae_f),    32'(n <= AE));
      check("fw_ovf",    32'(ovf_f),   32'(exp_ovf));
      check("fw_unf",    32'(unf_f),   32'(exp_unf));
      check("fw_out",    32'(out_f),   32'(exp_fw));
    end
  end

  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst = r; wr_en = w; rd_en = rd; buf_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held for two cycles.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_cnt",   32'(cnt_s),   32'd0);
    check("rst_empty", 32'(empty_s), 32'd1);
    check("rst_ae",    32'(ae_s),    32'd1);
    check("rst_full",  32'(full_s),  32'd0);
    check("rst_out",   32'(out_s),   32'd0);
    check("rst_out_f", 32'(out_f),   32'd0);

    // Fill with 1..8, then one rejected write of 99.
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'(k));
      if (k == 2) check("ae_at_2", 32'(ae_s), 32'd1);
      if (k == 3) check("ae_at_3", 32'(ae_s), 32'd0);
      if (k == 5) check("af_at_5", 32'(af_s), 32'd0);
      if (k == 6) check("af_at_6", 32'(af_s), 32'd1);
    end
    check("fill_full", 32'(full_s), 32'd1);
    check("fill_cnt",  32'(cnt_s),  32'd8);
    step(1'b0, 1'b1, 1'b0, 8'd99);
    check("ovf_pulse", 32'(ovf_s), 32'd1);
    check("ovf_cnt",   32'(cnt_s), 32'd8);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("ovf_clear", 32'(ovf_s), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("drain_order", 32'(out_s), 32'(k));
    end

    // Underflow on empty, then simultaneous write+read on empty.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("unf_pulse", 32'(unf_s), 32'd1);
    check("unf_hold",  32'(out_s), 32'd8);
    check("unf_cnt",   32'(cnt_s), 32'd0);
    step(1'b0, 1'b1, 1'b1, 8'd5);
    check("wr_rd_empty_unf", 32'(unf_s), 32'd1);
    check("wr_rd_empty_cnt", 32'(cnt_s), 32'd1);
    check("wr_rd_empty_fw",  32'(out_f), 32'd5);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("read_5", 32'(out_s), 32'd5);

    // Simultaneous write+read while full.
    for (int k = 11; k <= 18; k++) step(1'b0, 1'b1, 1'b0, 8'(k));
    step(1'b0, 1'b1, 1'b1, 8'd77);
    check("full_wr_rd_cnt",  32'(cnt_s),  32'd8);
    check("full_wr_rd_full", 32'(full_s), 32'd1);
    check("full_wr_rd_ovf",  32'(ovf_s),  32'd0);
    check("full_wr_rd_out",  32'(out_s),  32'd11);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 8'h00);
    check("last_is_77", 32'(out_s), 32'd77);

    // Wrap-around with interleaved single writes and reads.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, 1'b0, 8'(100 + i / 2));
      else begin
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("wrap_out", 32'(out_s), 32'(100 + i / 2));
      end
      check("wrap_cnt_le2", 32'(cnt_s <= 4'd2), 32'd1);
    end

    // FWFT head visibility, pop, and mid-stream reset.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'hA5);
    check("fwft_a5", 32'(out_f), 32'hA5);
    step(1'b0, 1'b1, 1'b0, 8'hB6);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("fwft_pop_b6", 32'(out_f), 32'hB6);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 8'(k + 1));
    check("fwft_cnt4", 32'(cnt_f), 32'd4);
    step(1'b1, 1'b1, 1'b1, 8'hEE);
    check("midrst_cnt",   32'(cnt_f),   32'd0);
    check("midrst_empty", 32'(empty_f), 32'd1);
    check("midrst_out",   32'(out_f),   32'd0);

    // Randomised traffic in alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 2000; i++) begin
      int pw;
      pw = ((i / 200) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 99) < pw,
           $urandom_range(0, 99) < (100 - pw),
           8'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the successor to the fixed 8x8 sync FIFO, with configurable width and depth, programmable almost-full and almost-empty thresholds, and error pulses for overflow and underflow. It can run in standard (registered-read) or first-word-fall-through (FWFT) mode. It is used as the generic buffering element between producer and consumer datapaths on the same clock.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, 6, almost_full asserts when fifo_cnt >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when fifo_cnt <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
CNT_W (localparam), $clog2(DEPTH)+1, width of fifo_cnt

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
buf_in  input  DATA_W  write data
wr_en  input  1  write request
rd_en  input  1  read request
buf_out  output  DATA_W  read data
empty  output  1  fifo_cnt == 0
full  output  1  fifo_cnt == DEPTH
almost_full  output  1  fifo_cnt >= AF_LEVEL
almost_empty  output  1  fifo_cnt <= AE_LEVEL
fifo_cnt  output  CNT_W  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset: clk and rst only (single clock domain); reset is synchronous, active-high. rst sampled high at a rising edge gives:
  - wr_ptr, rd_ptr and fifo_cnt = 0
  - empty=1, full=0, almost_empty=1, almost_full=0
  - overflow=0, underflow=0, buf_out=0
  - memory contents are not reset
- Reset mid-operation: all stored data is discarded and the next cycle behaves as freshly reset. rst has priority over wr_en and rd_en.
- Accept rules, evaluated on pre-edge state:
  - rd_acc = rd_en & !empty
  - wr_acc = wr_en & (!full | rd_acc)
- Simultaneous writes and reads:
  - Writing while full succeeds only if a read is accepted in the same cycle.
  - Reading while empty is rejected even if wr_en is high in the same cycle; the written word becomes readable next cycle.
- Count update:
  - wr_acc only: +1
  - rd_acc only: -1
  - both or neither: unchanged
- Flags: empty, full, almost_full and almost_empty are pure decodes of the registered fifo_cnt, so they update the same edge the count changes.
- Pointers: log2(DEPTH) bits wide; increment on acceptance and wrap naturally from DEPTH-1 to 0.
- Error pulses:
  - overflow=1 for exactly the cycle after an edge where wr_en=1 and !wr_acc
  - underflow likewise for rd_en=1 and !rd_acc
  - No effect on state.
- FWFT=0 (standard mode):
  - On rd_acc, buf_out <= mem[rd_ptr]; data is valid one cycle after rd_en.
  - buf_out holds its last value when there is no accepted read, including a rejected read.
- FWFT=1 (first-word-fall-through mode):
  - buf_out = mem[rd_ptr] whenever !empty; the head word is visible with no rd_en.
  - rd_en pops the head, and the next word appears the following cycle.
  - A word written into an empty FIFO appears on buf_out one cycle after the write edge, in the same cycle empty deasserts.
  - When empty, buf_out holds the last popped value, or 0 after reset.
- Memory: write at mem[wr_ptr] on wr_acc. Reading a slot in the same cycle as writing a different slot is safe because pointers never alias unless the FIFO is empty or full.

Test Plan:
- Reset/flags (DEPTH=8, AF=6, AE=2), rst high 2 cycles -> fifo_cnt=0, empty=1, almost_empty=1, full=0, buf_out=0. Then write 3 words -> almost_empty=0 after the 3rd write.
- Fill and overflow: write 1..8 -> full=1, fifo_cnt=8, almost_full=1 from count 6. A 9th write of 99 -> overflow pulses 1 cycle, count stays 8. Reading all 8 returns 1..8 in order; 99 is never read.
- Underflow/empty: rd_en on empty FIFO -> underflow pulses 1 cycle, buf_out unchanged, count 0. Simultaneous wr(5)+rd on empty -> read rejected, count=1, 5 read next.
- Full simultaneous: at count 8, wr(77)+rd in the same cycle -> both accepted, count stays 8, full stays 1. The read returns the oldest word and 77 is read last.
- Wrap-around: 20 cycles of interleaved single writes/reads of incrementing values through DEPTH=8 -> output sequence equals input sequence, count never exceeds 2.
- FWFT=1: write 0xA5 into empty -> buf_out=0xA5 the next cycle with no rd_en. rd_en pops it and buf_out shows the 2nd word the next cycle. Asserting rst mid-stream at count 4 -> count=0, empty=1 the next cycle.
